// File: rtl/debounced_key_pio.sv
// Avalon-MM key/switch PIO: synchronises and debounces WIDTH raw inputs, captures
// selectable rising/falling edges into a write-1-to-clear register and raises a level irq.
module debounced_key_pio #(
   parameter int   WIDTH           = 2,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1,
   parameter logic RISE_DEFAULT    = 1'b0,
   parameter logic FALL_DEFAULT    = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   typedef enum logic [2:0] {
      REG_DATA      = 3'd0,
      REG_RAW       = 3'd1,
      REG_IRQ_MASK  = 3'd2,
      REG_EDGE_CAP  = 3'd3,
      REG_EDGE_RISE = 3'd4,
      REG_EDGE_FALL = 3'd5
   } reg_addr_e;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  raw;
   logic [WIDTH-1:0]                  stable_q;
   logic [WIDTH-1:0]                  change;
   logic [WIDTH-1:0]                  rise;
   logic [WIDTH-1:0]                  fall;
   logic [WIDTH-1:0]                  irq_mask_q;
   logic [WIDTH-1:0]                  edge_cap_q;
   logic [WIDTH-1:0]                  edge_rise_q;
   logic [WIDTH-1:0]                  edge_fall_q;
   logic [WIDTH-1:0]                  wdata;
   logic [WIDTH-1:0]                  cap_clear;
   logic                              wr;
   logic [31:0]                       rd_mux;

   assign wr    = chipselect & ~write_n;
   assign wdata = writedata[WIDTH-1:0];

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic unused_wdata;
         assign unused_wdata = ^writedata[31:WIDTH];
      end
   endgenerate

   // Synchroniser idles at IDLE_LEVEL so a released reset never looks like a key press.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{{WIDTH{IDLE_LEVEL}}}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      end
   end

   assign raw = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               stable_q <= {WIDTH{IDLE_LEVEL}};
            end else begin
               stable_q <= raw;
            end
         end

         assign change = raw ^ stable_q;
      end else begin : g_count
         localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt_q [WIDTH];

         // NOTE: every always_comb output gets a default first so no latch is inferred.
         always_comb begin
            change = '0;
            for (int i = 0; i < WIDTH; i++) begin
               change[i] = (raw[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
            end
         end

         // NOTE: the counter array is small and reset explicitly so a mid-count reset discards it.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               stable_q <= {WIDTH{IDLE_LEVEL}};
               for (int i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= '0;
               end
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (raw[i] == stable_q[i]) begin
                     cnt_q[i] <= '0;
                  end else if (change[i]) begin
                     stable_q[i] <= raw[i];
                     cnt_q[i]    <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                  end
               end
            end
         end
      end
   endgenerate

   // On a change cycle the new debounced level is the synchroniser output itself.
   assign rise = change &  raw & edge_rise_q;
   assign fall = change & ~raw & edge_fall_q;

   assign cap_clear = (wr && address == REG_EDGE_CAP) ? wdata : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask_q  <= '0;
         edge_cap_q  <= '0;
         edge_rise_q <= {WIDTH{RISE_DEFAULT}};
         edge_fall_q <= {WIDTH{FALL_DEFAULT}};
      end else begin
         // Set after clear: an edge arriving with its own W1C is kept.
         edge_cap_q <= (edge_cap_q & ~cap_clear) | rise | fall;
         if (wr) begin
            case (reg_addr_e'(address))
               REG_IRQ_MASK:  irq_mask_q  <= wdata;
               REG_EDGE_RISE: edge_rise_q <= wdata;
               REG_EDGE_FALL: edge_fall_q <= wdata;
               default:       ;
            endcase
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_addr_e'(address))
         REG_DATA:      rd_mux = 32'(stable_q);
         REG_RAW:       rd_mux = 32'(raw);
         REG_IRQ_MASK:  rd_mux = 32'(irq_mask_q);
         REG_EDGE_CAP:  rd_mux = 32'(edge_cap_q);
         REG_EDGE_RISE: rd_mux = 32'(edge_rise_q);
         REG_EDGE_FALL: rd_mux = 32'(edge_fall_q);
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

   assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_debounced_key_pio.sv
// Bench for debounced_key_pio: directed scenarios plus a random phase, checked by a
// scoreboard fed from a window-based behavioural model of the key PIO.
module tb_debounced_key_pio;

   localparam int         W    = 4;
   localparam int         SS   = 2;
   localparam int         DC   = 4;
   localparam logic [3:0] IDLE = 4'hF;
   localparam logic [3:0] RRST = 4'h0;
   localparam logic [3:0] FRST = 4'hF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = IDLE;
   logic [31:0] readdata;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   debounced_key_pio #(
      .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] m_pipe[$];   // in_port samples still travelling through the synchroniser
   logic [3:0] m_win[$];    // the last DC synchronised samples
   logic [3:0] m_raw, m_stable, m_mask, m_cap, m_rise, m_fall;
   logic       m_irq;

   function automatic logic [31:0] m_reg(input logic [2:0] a);
      case (a)
         3'd0:    return 32'(m_stable);
         3'd1:    return 32'(m_raw);
         3'd2:    return 32'(m_mask);
         3'd3:    return 32'(m_cap);
         3'd4:    return 32'(m_rise);
         3'd5:    return 32'(m_fall);
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      sb.delete();
      m_pipe.delete();
      m_win.delete();
      for (int k = 0; k < SS - 1; k++) m_pipe.push_back(IDLE);
      for (int k = 0; k < DC; k++) m_win.push_back(IDLE);
      m_raw = IDLE; m_stable = IDLE; m_mask = '0; m_cap = '0;
      m_rise = RRST; m_fall = FRST; m_irq = 1'b0;
   endtask

   always @(posedge clk or negedge reset_n) begin
      logic [3:0] chg, ev, clr;
      if (!reset_n) begin
         m_reset();
      end else begin
         if (chipselect && write_n) sb.push_back('{addr: address, data: m_reg(address)});
         // A level is accepted once it has been seen for DC consecutive samples.
         m_win.push_back(m_raw);
         void'(m_win.pop_front());
         chg = '0;
         for (int i = 0; i < W; i++) begin
            chg[i] = 1'b1;
            foreach (m_win[k]) if (m_win[k][i] == m_stable[i]) chg[i] = 1'b0;
         end
         ev  = (chg & m_raw & m_rise) | (chg & ~m_raw & m_fall);
         clr = (chipselect && !write_n && address == 3'd3) ? writedata[3:0] : 4'h0;
         m_cap = (m_cap & ~clr) | ev;
         if (chipselect && !write_n) begin
            if (address == 3'd2) m_mask = writedata[3:0];
            if (address == 3'd4) m_rise = writedata[3:0];
            if (address == 3'd5) m_fall = writedata[3:0];
         end
         m_stable = m_stable ^ chg;
         m_pipe.push_back(in_port);
         m_raw = m_pipe.pop_front();
         m_irq = |(m_cap & m_mask);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("read addr %0d", e.addr), readdata, e.data);
         end
         check("irq", 32'(irq), 32'(m_irq));
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
      chipselect = cs; write_n = wn; address = a; writedata = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) bus(1'b0, 1'b1, 3'd0, 32'd0);
   endtask

   task automatic rd(input logic [2:0] a);
      bus(1'b1, 1'b1, a, 32'd0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus(1'b1, 1'b0, a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset register values.
      for (int a = 0; a < 8; a++) rd(3'(a));

      // Falling edge on ch0 with its interrupt enabled; DATA read every cycle.
      wr(3'd2, 32'h1);
      in_port[0] = 1'b0;
      for (int k = 0; k < 10; k++) rd(3'd0);
      rd(3'd3); rd(3'd1);

      // Short glitches on ch1 never reach DATA.
      wr(3'd3, 32'hF);
      for (int p = 0; p < 3; p++) begin
         in_port[1] = 1'b0;
         rd(3'd1); rd(3'd0); rd(3'd1);
         in_port[1] = 1'b1;
         rd(3'd1); rd(3'd0); rd(3'd3);
      end
      idle(6); rd(3'd0); rd(3'd3);

      // W1C clears only the written bits.
      in_port[0] = 1'b1; idle(8);
      wr(3'd3, 32'hF);
      in_port[1:0] = 2'b00; idle(8);
      rd(3'd3);
      wr(3'd3, 32'h1);
      rd(3'd3);
      // A ch0 edge landing on a W1C cycle keeps its capture bit.
      in_port[0] = 1'b1; idle(8);
      in_port[0] = 1'b0;
      begin
         int n = 0;
         while (m_stable[0] !== 1'b0 && n < 20) begin
            wr(3'd3, 32'h1);
            n++;
         end
         check("w1c collision reached", 32'(n < 20), 32'd1);
      end
      rd(3'd3);

      // Per-channel edge selection.
      wr(3'd4, 32'h4); wr(3'd5, 32'h0); wr(3'd3, 32'hF);
      in_port[2] = 1'b0; idle(8); rd(3'd3);
      in_port[2] = 1'b1; idle(8); rd(3'd3);
      wr(3'd3, 32'hF);
      in_port[2] = 1'b0; idle(8); rd(3'd3);
      in_port[3] = 1'b0; idle(8); in_port[3] = 1'b1; idle(8); rd(3'd3); rd(3'd0);

      // Reset in the middle of a debounce count.
      wr(3'd3, 32'hF); wr(3'd5, 32'hF); wr(3'd2, 32'hF);
      in_port = 4'hF; idle(8);
      in_port[0] = 1'b0; wr(3'd3, 32'h0); idle(3);
      reset_n = 1'b0;
      #1;
      check("readdata in reset", readdata, 32'd0);
      check("irq in reset", 32'(irq), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 10; k++) rd(3'd0);
      rd(3'd3); rd(3'd1);

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         int op;
         if ($urandom_range(5, 0) == 0) in_port = in_port ^ 4'(1 << $urandom_range(3, 0));
         op = int'($urandom_range(99, 0));
         if (op < 60)      rd(3'($urandom_range(7, 0)));
         else if (op < 75) wr(3'($urandom_range(7, 0)), $urandom);
         else              idle(1);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
